id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage that sits directly downstream of the 32-entry register file.
- Registers the register-file read data (rd0/rd1) and the decoded fields for the EX stage.
- Forwards EX and MEM results over the stale read data. The register file already bypasses the WB write.
- Detects load-use hazards, inserts bubbles, and honours flush and downstream hold.

---
 rtl/id_ex_stage_if.sv | 53 +++++
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID slot fields, forwarding sources and control in, EX slot fields out.
interface id_ex_stage_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned RW = 5;

  logic              id_valid;
  logic [RW-1:0]     id_ra0;
  logic [RW-1:0]     id_ra1;
  logic              id_use0;
  logic              id_use1;
  logic [WIDTH-1:0]  id_rd0;
  logic [WIDTH-1:0]  id_rd1;
  logic [WIDTH-1:0]  id_imm;
  logic [RW-1:0]     id_wa;
  logic              id_regwrite;
  logic              id_memread;
  logic [CTRL_W-1:0] id_ctrl;
  logic [WIDTH-1:0]  ex_result;
  logic [RW-1:0]     mem_wa;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wd;
  logic              flush;
  logic              ex_hold;
  logic              stall_id;
  logic              ex_valid;
  logic [WIDTH-1:0]  ex_a;
  logic [WIDTH-1:0]  ex_b;
  logic [WIDTH-1:0]  ex_imm;
  logic [RW-1:0]     ex_wa;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_ra0, id_ra1, id_use0, id_use1, id_rd0, id_rd1, id_imm,
           id_wa, id_regwrite, id_memread, id_ctrl, ex_result, mem_wa, mem_we,
           mem_wd, flush, ex_hold,
    input  stall_id, ex_valid, ex_a, ex_b, ex_imm, ex_wa, ex_regwrite,
           ex_memread, ex_ctrl, bubble_cnt
  );

  modport slave (
    input  id_valid, id_ra0, id_ra1, id_use0, id_use1, id_rd0, id_rd1, id_imm,
           id_wa, id_regwrite, id_memread, id_ctrl, ex_result, mem_wa, mem_we,
           mem_wd, flush, ex_hold,
    output stall_id, ex_valid, ex_a, ex_b, ex_imm, ex_wa, ex_regwrite,
           ex_memread, ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with EX/MEM operand forwarding,
// load-use bubble insertion, flush and downstream hold.
module id_ex_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);
  localparam int unsigned RW = 5;

  logic              ex_valid_q;
  logic [WIDTH-1:0]  ex_a_q;
  logic [WIDTH-1:0]  ex_b_q;
  logic [WIDTH-1:0]  ex_imm_q;
  logic [RW-1:0]     ex_wa_q;
  logic              ex_regwrite_q;
  logic              ex_memread_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  logic              ex_fwd_ok;
  logic              mem_fwd_ok;
  logic              hz;
  logic [WIDTH-1:0]  fwd_a;
  logic [WIDTH-1:0]  fwd_b;

  // EX beats MEM: the instruction in EX is the younger producer; a load in EX has no data yet.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [RW-1:0]    ra,
    input logic [WIDTH-1:0] rd,
    input logic             ex_ok,
    input logic [RW-1:0]    ex_wa,
    input logic [WIDTH-1:0] ex_res,
    input logic             mem_ok,
    input logic [RW-1:0]    mem_wa,
    input logic [WIDTH-1:0] mem_wd
  );
    if (ex_ok && (ex_wa == ra))        return ex_res;
    else if (mem_ok && (mem_wa == ra)) return mem_wd;
    else                               return rd;
  endfunction

  always_comb begin
    ex_fwd_ok  = ex_valid_q & ex_regwrite_q & ~ex_memread_q & (ex_wa_q != '0);
    mem_fwd_ok = bus.mem_we & (bus.mem_wa != '0);
    hz = ex_valid_q & ex_memread_q & ex_regwrite_q & (ex_wa_q != '0) & bus.id_valid &
         ((bus.id_use0 & (bus.id_ra0 == ex_wa_q)) | (bus.id_use1 & (bus.id_ra1 == ex_wa_q)));
    fwd_a = fwd_sel(bus.id_ra0, bus.id_rd0, ex_fwd_ok, ex_wa_q, bus.ex_result,
                    mem_fwd_ok, bus.mem_wa, bus.mem_wd);
    fwd_b = fwd_sel(bus.id_ra1, bus.id_rd1, ex_fwd_ok, ex_wa_q, bus.ex_result,
                    mem_fwd_ok, bus.mem_wa, bus.mem_wd);
  end

  assign bus.stall_id = bus.ex_hold | (hz & ~bus.flush);

  // Update priority: reset, hold, flush, hazard, capture, otherwise bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_imm_q      <= '0;
      ex_wa_q       <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_ctrl_q     <= '0;
      bubble_cnt_q  <= '0;
    end else if (bus.ex_hold) begin
      ex_valid_q    <= ex_valid_q;
    end else if (!bus.flush && !hz && bus.id_valid) begin
      ex_valid_q    <= 1'b1;
      ex_a_q        <= fwd_a;
      ex_b_q        <= fwd_b;
      ex_imm_q      <= bus.id_imm;
      ex_wa_q       <= bus.id_wa;
      ex_regwrite_q <= bus.id_regwrite;
      ex_memread_q  <= bus.id_memread;
      ex_ctrl_q     <= bus.id_ctrl;
    end else begin
      ex_valid_q    <= 1'b0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_imm_q      <= '0;
      ex_wa_q       <= '0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_ctrl_q     <= '0;
      if (!bus.flush && hz && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_a        = ex_a_q;
  assign bus.ex_b        = ex_b_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_wa       = ex_wa_q;
  assign bus.ex_regwrite = ex_regwrite_q;
  assign bus.ex_memread  = ex_memread_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding, load-use, flush/hold, counter saturation.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.WIDTH(32), .CTRL_W(8), .CNT_W(16)) b0 ();
  id_ex_stage_if #(.WIDTH(32), .CTRL_W(8), .CNT_W(2))  b1 ();

  id_ex_stage #(.WIDTH(32), .CTRL_W(8), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  id_ex_stage #(.WIDTH(32), .CTRL_W(8), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic zero0();
    b0.id_valid = 0; b0.id_ra0 = 0; b0.id_ra1 = 0; b0.id_use0 = 0; b0.id_use1 = 0;
    b0.id_rd0 = 0; b0.id_rd1 = 0; b0.id_imm = 0; b0.id_wa = 0; b0.id_regwrite = 0;
    b0.id_memread = 0; b0.id_ctrl = 0; b0.ex_result = 0; b0.mem_wa = 0; b0.mem_we = 0;
    b0.mem_wd = 0; b0.flush = 0; b0.ex_hold = 0;
  endtask

  task automatic zero1();
    b1.id_valid = 0; b1.id_ra0 = 0; b1.id_ra1 = 0; b1.id_use0 = 0; b1.id_use1 = 0;
    b1.id_rd0 = 0; b1.id_rd1 = 0; b1.id_imm = 0; b1.id_wa = 0; b1.id_regwrite = 0;
    b1.id_memread = 0; b1.id_ctrl = 0; b1.ex_result = 0; b1.mem_wa = 0; b1.mem_we = 0;
    b1.mem_wd = 0; b1.flush = 0; b1.ex_hold = 0;
  endtask

  task automatic rand0();
    b0.id_valid = 1'($urandom()); b0.id_ra0 = 5'($urandom()); b0.id_ra1 = 5'($urandom());
    b0.id_use0 = 1'($urandom()); b0.id_use1 = 1'($urandom()); b0.id_rd0 = $urandom();
    b0.id_rd1 = $urandom(); b0.id_imm = $urandom(); b0.id_wa = 5'($urandom());
    b0.id_regwrite = 1'($urandom()); b0.id_memread = 1'($urandom()); b0.id_ctrl = 8'($urandom());
    b0.ex_result = $urandom(); b0.mem_wa = 5'($urandom()); b0.mem_we = 1'($urandom());
    b0.mem_wd = $urandom(); b0.flush = 1'($urandom()); b0.ex_hold = 1'($urandom());
  endtask

  // Drive an ID-slot load to $8 with no source reads.
  task automatic lw8_0();
    b0.id_valid = 1; b0.id_wa = 8; b0.id_regwrite = 1; b0.id_memread = 1;
    b0.id_ra0 = 0; b0.id_ra1 = 0; b0.id_use0 = 0; b0.id_use1 = 0; b0.mem_we = 0;
  endtask

  task automatic chk_bubble0(input string tag);
    chk({tag, "_valid"}, 32'(b0.ex_valid), 32'd0);
    chk({tag, "_rw"},    32'(b0.ex_regwrite), 32'd0);
    chk({tag, "_mr"},    32'(b0.ex_memread), 32'd0);
    chk({tag, "_wa"},    32'(b0.ex_wa), 32'd0);
    chk({tag, "_ctrl"},  32'(b0.ex_ctrl), 32'd0);
    chk({tag, "_a"},     b0.ex_a, 32'd0);
    chk({tag, "_b"},     b0.ex_b, 32'd0);
    chk({tag, "_imm"},   b0.ex_imm, 32'd0);
  endtask

  initial begin
    rst = 1;
    zero1();
    rand0();
    tick();
    rand0();
    tick();
    chk_bubble0("rst");
    chk("rst_cnt", 32'(b0.bubble_cnt), 32'd0);
    zero0();
    settle();
    chk("rst_stall", 32'(b0.stall_id), 32'd0);

    rst = 0;
    tick();
    tick();
    chk_bubble0("idle");
    chk("idle_cnt", 32'(b0.bubble_cnt), 32'd0);

    // Plain capture, no forwarding matches
    b0.id_valid = 1; b0.id_ra0 = 1; b0.id_ra1 = 2; b0.id_use0 = 1; b0.id_use1 = 1;
    b0.id_rd0 = 32'h11; b0.id_rd1 = 32'h22; b0.id_imm = 32'h5; b0.id_wa = 3;
    b0.id_regwrite = 1; b0.id_ctrl = 8'h5A;
    settle();
    chk("cap_stall", 32'(b0.stall_id), 32'd0);
    tick();
    chk("cap_a", b0.ex_a, 32'h11);
    chk("cap_b", b0.ex_b, 32'h22);
    chk("cap_imm", b0.ex_imm, 32'h5);
    chk("cap_wa", 32'(b0.ex_wa), 32'd3);
    chk("cap_valid", 32'(b0.ex_valid), 32'd1);
    chk("cap_rw", 32'(b0.ex_regwrite), 32'd1);
    chk("cap_ctrl", 32'(b0.ex_ctrl), 32'h5A);

    // Put add to $5 into EX
    b0.id_wa = 5; b0.id_ra0 = 0; b0.id_ra1 = 0; b0.id_ctrl = 8'h01;
    tick();
    // EX and MEM both match ra0: EX wins
    b0.id_ra0 = 5; b0.id_use0 = 1; b0.id_rd0 = 32'h1234;
    b0.id_ra1 = 6; b0.id_use1 = 1; b0.id_rd1 = 32'h66;
    b0.ex_result = 32'hAAAA; b0.mem_we = 1; b0.mem_wa = 5; b0.mem_wd = 32'hBBBB;
    b0.id_wa = 0;
    tick();
    chk("exfwd_a", b0.ex_a, 32'hAAAA);
    chk("exfwd_b", b0.ex_b, 32'h66);
    // EX now writes $0: neither EX nor MEM $0 may forward
    b0.id_ra0 = 0; b0.id_rd0 = 32'h1357; b0.id_ra1 = 0; b0.id_rd1 = 32'h2468;
    b0.mem_wa = 0;
    tick();
    chk("r0_a", b0.ex_a, 32'h1357);
    chk("r0_b", b0.ex_b, 32'h2468);
    // MEM-only forward on B
    b0.id_ra1 = 9; b0.mem_wa = 9; b0.mem_wd = 32'hBBBB; b0.id_rd0 = 32'h77; b0.id_wa = 7;
    tick();
    chk("memfwd_b", b0.ex_b, 32'hBBBB);
    chk("memfwd_a", b0.ex_a, 32'h77);

    // Load-use on rt
    lw8_0();
    tick();
    chk("lw_mr", 32'(b0.ex_memread), 32'd1);
    chk("lw_wa", 32'(b0.ex_wa), 32'd8);
    b0.id_memread = 0; b0.id_wa = 10; b0.id_ra0 = 1; b0.id_use0 = 1; b0.id_rd0 = 32'h0101;
    b0.id_ra1 = 8; b0.id_use1 = 1; b0.id_rd1 = 32'h0BAD; b0.ex_result = 32'hDEAD;
    settle();
    chk("lu_stall", 32'(b0.stall_id), 32'd1);
    tick();
    chk_bubble0("lu_bub");
    chk("lu_cnt", 32'(b0.bubble_cnt), 32'd1);
    b0.mem_we = 1; b0.mem_wa = 8; b0.mem_wd = 32'hCAFE;
    settle();
    chk("lu2_stall", 32'(b0.stall_id), 32'd0);
    tick();
    chk("lu2_b", b0.ex_b, 32'hCAFE);
    chk("lu2_a", b0.ex_a, 32'h0101);
    chk("lu2_valid", 32'(b0.ex_valid), 32'd1);
    chk("lu2_wa", 32'(b0.ex_wa), 32'd10);
    chk("lu2_cnt", 32'(b0.bubble_cnt), 32'd1);

    // Same pattern with use1=0: no hazard
    lw8_0();
    tick();
    b0.id_memread = 0; b0.id_wa = 10; b0.id_ra0 = 1; b0.id_use0 = 0;
    b0.id_ra1 = 8; b0.id_use1 = 0; b0.id_rd1 = 32'h0BAD;
    settle();
    chk("nouse_stall", 32'(b0.stall_id), 32'd0);
    tick();
    chk("nouse_valid", 32'(b0.ex_valid), 32'd1);
    chk("nouse_b", b0.ex_b, 32'h0BAD);
    chk("nouse_cnt", 32'(b0.bubble_cnt), 32'd1);

    // Flush together with a hazard
    lw8_0();
    tick();
    b0.id_memread = 0; b0.id_wa = 10; b0.id_ra1 = 8; b0.id_use1 = 1; b0.flush = 1;
    settle();
    chk("flhz_stall", 32'(b0.stall_id), 32'd0);
    tick();
    chk_bubble0("flhz");
    chk("flhz_cnt", 32'(b0.bubble_cnt), 32'd1);

    // Flush under ex_hold: state frozen
    b0.flush = 0; b0.id_wa = 4; b0.id_rd0 = 32'h44; b0.id_ra0 = 1; b0.id_use0 = 0;
    b0.id_ra1 = 2; b0.id_use1 = 0;
    tick();
    chk("pre_hold_a", b0.ex_a, 32'h44);
    b0.flush = 1; b0.ex_hold = 1; b0.id_rd0 = 32'h99; b0.id_wa = 6;
    settle();
    chk("hold_stall", 32'(b0.stall_id), 32'd1);
    tick();
    chk("hold_valid", 32'(b0.ex_valid), 32'd1);
    chk("hold_a", b0.ex_a, 32'h44);
    chk("hold_wa", 32'(b0.ex_wa), 32'd4);
    chk("hold_cnt", 32'(b0.bubble_cnt), 32'd1);
    zero0();

    // Saturation on the CNT_W=2 instance: five load-use bubbles
    for (int i = 1; i <= 5; i++) begin
      b1.id_valid = 1; b1.id_wa = 8; b1.id_regwrite = 1; b1.id_memread = 1;
      b1.id_ra1 = 0; b1.id_use1 = 0;
      tick();
      b1.id_wa = 9; b1.id_memread = 0; b1.id_ra1 = 8; b1.id_use1 = 1;
      settle();
      chk($sformatf("sat%0d_stall", i), 32'(b1.stall_id), 32'd1);
      tick();
      chk($sformatf("sat%0d_cnt", i), 32'(b1.bubble_cnt), (i > 3) ? 32'd3 : 32'(i));
    end

    // Mid-stream reset
    b0.id_valid = 1; b0.id_wa = 2; b0.id_rd0 = 32'h5; b0.id_regwrite = 1;
    tick();
    chk("pre_rst_valid", 32'(b0.ex_valid), 32'd1);
    rst = 1;
    tick();
    chk("mrst_valid", 32'(b0.ex_valid), 32'd0);
    chk("mrst_cnt0", 32'(b0.bubble_cnt), 32'd0);
    chk("mrst_cnt1", 32'(b1.bubble_cnt), 32'd0);
    chk("mrst_valid1", 32'(b1.ex_valid), 32'd0);
    rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
